// File: rtl/cdi_ddram_pkg.sv
// Shared types and constants for the CD-i DDRAM arbiter: Avalon widths, FSM states,
// the per-port command record and the burst-length normalisation helper.
package cdi_ddram_pkg;

    localparam int DDR_AW     = 29;
    localparam int DDR_DW     = 64;
    localparam int DDR_BEW    = 8;
    localparam int PORT_VIDEO = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT
    } ddr_state_t;

    typedef struct packed {
        logic               we;
        logic [DDR_AW-1:0]  addr;
        logic [7:0]         len;
        logic [DDR_DW-1:0]  wdata;
        logic [DDR_BEW-1:0] be;
    } ddr_cmd_t;

    // Writes are always one beat; a zero-length read still moves one beat.
    function automatic logic [7:0] burst_count(input ddr_cmd_t cmd, input int max_burst);
        if (cmd.we)                     return 8'd1;
        if (cmd.len == 8'd0)            return 8'd1;
        if (int'(cmd.len) > max_burst)  return 8'(max_burst);
        return cmd.len;
    endfunction

endpackage

// File: rtl/cdi_rr_pick.sv
// Combinational round-robin picker: first requesting line at or after ptr_i, wrapping.
// Output is one-hot, or all zero when nothing requests.
module cdi_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdi_ddram_arbiter.sv
// Shares the MiSTer DDRAM Avalon port between CD-i memory clients: port 0 (video) has fixed
// priority, the rest are served round-robin, one transaction in flight at a time.
module cdi_ddram_arbiter
    import cdi_ddram_pkg::*;
#(
    parameter int NPORTS    = 3,
    parameter int MAX_BURST = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NPORTS-1:0]                req,
    input  logic [NPORTS-1:0]                we,
    input  logic [NPORTS-1:0][DDR_AW-1:0]    addr,
    input  logic [NPORTS-1:0][7:0]           len,
    input  logic [NPORTS-1:0][DDR_DW-1:0]    wdata,
    input  logic [NPORTS-1:0][DDR_BEW-1:0]   be,
    output logic [DDR_DW-1:0]                rdata,
    output logic [NPORTS-1:0]                rvalid,
    output logic [NPORTS-1:0]                done,
    input  logic                             DDRAM_BUSY,
    input  logic [DDR_DW-1:0]                DDRAM_DOUT,
    input  logic                             DDRAM_DOUT_READY,
    output logic                             DDRAM_RD,
    output logic                             DDRAM_WE,
    output logic [DDR_AW-1:0]                DDRAM_ADDR,
    output logic [7:0]                       DDRAM_BURSTCNT,
    output logic [DDR_DW-1:0]                DDRAM_DIN,
    output logic [DDR_BEW-1:0]               DDRAM_BE
);

    localparam int IW = $clog2(NPORTS);
    localparam int NR = NPORTS - 1;
    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    ddr_state_t  state_q;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [7:0]    cnt_q;

    logic [NR-1:0] rr_gnt;
    logic [PW-1:0] rr_ptr;
    logic [IW-1:0] sel_idx;
    ddr_cmd_t      sel_cmd;

    // The RR pointer holds a port number 1..NR; the picker indexes its lines from 0.
    assign rr_ptr = PW'(ptr_q - IW'(1));
    assign ptr_d  = (gnt_q == IW'(NR)) ? IW'(1) : gnt_q + IW'(1);

    cdi_rr_pick #(
        .N  (NR),
        .PW (PW)
    ) u_pick (
        .req_i (req[NPORTS-1:1]),
        .ptr_i (rr_ptr),
        .gnt_o (rr_gnt)
    );

    always_comb begin
        sel_idx = '0;
        if (req[PORT_VIDEO]) begin
            sel_idx = IW'(PORT_VIDEO);
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (rr_gnt[i]) sel_idx = IW'(i + 1);
            end
        end
        sel_cmd.we    = we[sel_idx];
        sel_cmd.addr  = addr[sel_idx];
        sel_cmd.len   = len[sel_idx];
        sel_cmd.wdata = wdata[sel_idx];
        sel_cmd.be    = be[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            ptr_q          <= IW'(1);
            cnt_q          <= '0;
            rdata          <= '0;
            rvalid         <= '0;
            done           <= '0;
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
        end else begin
            // NOTE: pulses default low every cycle and are only set by the branch that fires them.
            rvalid <= '0;
            done   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q          <= sel_idx;
                        DDRAM_RD       <= !sel_cmd.we;
                        DDRAM_WE       <= sel_cmd.we;
                        DDRAM_ADDR     <= sel_cmd.addr;
                        DDRAM_BURSTCNT <= burst_count(sel_cmd, MAX_BURST);
                        DDRAM_DIN      <= sel_cmd.wdata;
                        DDRAM_BE       <= sel_cmd.be;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        DDRAM_WE <= 1'b0;
                        if (DDRAM_WE) begin
                            done[gnt_q] <= 1'b1;
                            if (gnt_q != IW'(PORT_VIDEO)) ptr_q <= ptr_d;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= DDRAM_BURSTCNT;
                            state_q <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        rdata         <= DDRAM_DOUT;
                        rvalid[gnt_q] <= 1'b1;
                        cnt_q         <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            done[gnt_q] <= 1'b1;
                            if (gnt_q != IW'(PORT_VIDEO)) ptr_q <= ptr_d;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdi_ddram_arbiter.sv
// Directed bench for cdi_ddram_arbiter: a table of single-port transactions plus hand-written
// arbitration, round-robin and mid-burst reset sequences. Inputs driven and outputs sampled on negedge.
module tb_cdi_ddram_arbiter;

    localparam int NP = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP-1:0]      req, we;
    logic [NP-1:0][28:0] addr;
    logic [NP-1:0][7:0]  len;
    logic [NP-1:0][63:0] wdata;
    logic [NP-1:0][7:0]  be;
    logic [63:0]        rdata;
    logic [NP-1:0]      rvalid, done;
    logic               DDRAM_BUSY, DDRAM_DOUT_READY;
    logic [63:0]        DDRAM_DOUT;
    logic               DDRAM_RD, DDRAM_WE;
    logic [28:0]        DDRAM_ADDR;
    logic [7:0]         DDRAM_BURSTCNT;
    logic [63:0]        DDRAM_DIN;
    logic [7:0]         DDRAM_BE;

    int n_checks = 0;
    int n_fail   = 0;

    cdi_ddram_arbiter #(.NPORTS(NP), .MAX_BURST(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .we               (we),
        .addr             (addr),
        .len              (len),
        .wdata            (wdata),
        .be               (be),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .done             (done),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        w;
        logic [28:0] a;
        logic [7:0]  l;
        logic [63:0] d;
        logic [7:0]  m;
        int          busy;
        logic [7:0]  exp_bc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bdata(input int p, input int b);
        return {8'hA5, 8'(p), 16'(b), 32'h1357_9BDF ^ ~32'(b)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " RD"},       64'(DDRAM_RD), 64'd0);
        check({tag, " WE"},       64'(DDRAM_WE), 64'd0);
        check({tag, " ADDR"},     64'(DDRAM_ADDR), 64'd0);
        check({tag, " BURSTCNT"}, 64'(DDRAM_BURSTCNT), 64'd0);
        check({tag, " DIN"},      DDRAM_DIN, 64'd0);
        check({tag, " BE"},       64'(DDRAM_BE), 64'd0);
        check({tag, " rvalid"},   64'(rvalid), 64'd0);
        check({tag, " done"},     64'(done), 64'd0);
        check({tag, " rdata"},    rdata, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [NP-1:0] oh;
        string tag;
        oh = '0;
        oh[v.port] = 1'b1;
        tag = $sformatf("v%0d", idx);
        req = '0;
        we  = '0;
        req[v.port]   = 1'b1;
        we[v.port]    = v.w;
        addr[v.port]  = v.a;
        len[v.port]   = v.l;
        wdata[v.port] = v.d;
        be[v.port]    = v.m;
        @(negedge clk);
        for (int k = 0; k <= v.busy; k++) begin
            check({tag, " RD"},       64'(DDRAM_RD), 64'(!v.w));
            check({tag, " WE"},       64'(DDRAM_WE), 64'(v.w));
            check({tag, " ADDR"},     64'(DDRAM_ADDR), 64'(v.a));
            check({tag, " BURSTCNT"}, 64'(DDRAM_BURSTCNT), 64'(v.exp_bc));
            check({tag, " DIN"},      DDRAM_DIN, v.d);
            check({tag, " BE"},       64'(DDRAM_BE), 64'(v.m));
            check({tag, " done early"}, 64'(done), 64'd0);
            DDRAM_BUSY = (k < v.busy);
            @(negedge clk);
        end
        check({tag, " cmd drop"}, 64'({DDRAM_RD, DDRAM_WE}), 64'd0);
        if (v.w) begin
            check({tag, " wr done"}, 64'(done), 64'(oh));
            req = '0;
            @(negedge clk);
            check({tag, " done one cycle"}, 64'(done), 64'd0);
        end else begin
            check({tag, " rd done early"}, 64'(done), 64'd0);
            for (int b = 0; b < int'(v.exp_bc); b++) begin
                if (b == 1 && v.exp_bc > 8'd2) begin
                    DDRAM_DOUT_READY = 1'b0;
                    @(negedge clk);
                    check({tag, " gap rvalid"}, 64'(rvalid), 64'd0);
                end
                DDRAM_DOUT       = bdata(v.port, b);
                DDRAM_DOUT_READY = 1'b1;
                @(negedge clk);
                check($sformatf("%s beat%0d rvalid", tag, b), 64'(rvalid), 64'(oh));
                check($sformatf("%s beat%0d rdata", tag, b), rdata, bdata(v.port, b));
                check($sformatf("%s beat%0d done", tag, b), 64'(done),
                      (b == int'(v.exp_bc) - 1) ? 64'(oh) : 64'd0);
            end
            DDRAM_DOUT_READY = 1'b0;
            req = '0;
            @(negedge clk);
            check({tag, " idle after"}, 64'({rvalid, done}), 64'd0);
        end
    endtask

    // Waits for a command, checks which port's address it carries, serves one read beat.
    task automatic serve1(input int p, input string tag);
        logic [NP-1:0] oh;
        int n;
        oh = '0;
        oh[p] = 1'b1;
        n = 0;
        while (!(DDRAM_RD || DDRAM_WE) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " cmd"}, 64'(DDRAM_RD), 64'd1);
        check({tag, " grant addr"}, 64'(DDRAM_ADDR), 64'(29'h1000 + 29'(p)));
        @(negedge clk);
        DDRAM_DOUT       = bdata(p, 0);
        DDRAM_DOUT_READY = 1'b1;
        @(negedge clk);
        DDRAM_DOUT_READY = 1'b0;
        check({tag, " rvalid"}, 64'(rvalid), 64'(oh));
        check({tag, " done"},   64'(done), 64'(oh));
        check({tag, " rdata"},  rdata, bdata(p, 0));
    endtask

    task automatic setup_seq_ports();
        for (int p = 0; p < NP; p++) begin
            addr[p]  = 29'h1000 + 29'(p);
            len[p]   = 8'd1;
            wdata[p] = '0;
            be[p]    = '0;
        end
        we = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{port: 1, w: 1'b0, a: 29'h100,       l: 8'd4,   d: 64'h0,                   m: 8'h00, busy: 0, exp_bc: 8'd4};
        vecs[1] = '{port: 2, w: 1'b1, a: 29'h0ABCDE,    l: 8'd37,  d: 64'hDEADBEEF_01234567,   m: 8'h0F, busy: 3, exp_bc: 8'd1};
        vecs[2] = '{port: 1, w: 1'b0, a: 29'h1FFFFFFF,  l: 8'd0,   d: 64'h1111_2222_3333_4444, m: 8'h81, busy: 1, exp_bc: 8'd1};
        vecs[3] = '{port: 2, w: 1'b0, a: 29'h200,       l: 8'd200, d: 64'h0,                   m: 8'h00, busy: 0, exp_bc: 8'd64};
        vecs[4] = '{port: 0, w: 1'b0, a: 29'h300,       l: 8'd2,   d: 64'h0,                   m: 8'h00, busy: 2, exp_bc: 8'd2};
        vecs[5] = '{port: 0, w: 1'b1, a: 29'h301,       l: 8'd9,   d: 64'h0123_4567_89AB_CDEF, m: 8'hFF, busy: 0, exp_bc: 8'd1};
        vecs[6] = '{port: 1, w: 1'b0, a: 29'h400,       l: 8'd64,  d: 64'h0,                   m: 8'h00, busy: 0, exp_bc: 8'd64};
        vecs[7] = '{port: 2, w: 1'b0, a: 29'h500,       l: 8'd65,  d: 64'h0,                   m: 8'h00, busy: 1, exp_bc: 8'd64};

        reset = 1'b1;
        req = '0; we = '0; addr = '0; len = '0; wdata = '0; be = '0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Fresh reset: pointer back to port 1.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        setup_seq_ports();
        @(negedge clk);

        // Simultaneous port 0 and port 1: video first, then port 1.
        req = 3'b011;
        serve1(0, "prio p0");
        req[0] = 1'b0;
        serve1(1, "prio p1");
        req = '0;
        @(negedge clk);

        // Ports 1 and 2 continuously; pointer is now at port 2.
        req = 3'b110;
        serve1(2, "rr0");
        serve1(1, "rr1");
        serve1(2, "rr2");
        serve1(1, "rr3");
        req = '0;
        @(negedge clk);

        // A port-0 transaction must not move the pointer (still at port 2).
        req = 3'b001;
        serve1(0, "ptr p0");
        req = 3'b110;
        serve1(2, "ptr after p0");
        serve1(1, "ptr next");
        req = '0;
        @(negedge clk);

        // Reset after 2 of 8 beats.
        len[1] = 8'd8;
        req = 3'b010;
        @(negedge clk);
        check("mid cmd", 64'(DDRAM_BURSTCNT), 64'd8);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            DDRAM_DOUT = bdata(1, b);
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk);
            check($sformatf("mid beat%0d rvalid", b), 64'(rvalid), 64'(3'b010));
        end
        DDRAM_DOUT_READY = 1'b0;
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        check_reset_outputs("mid reset");
        reset = 1'b0;
        for (int b = 2; b < 8; b++) begin
            DDRAM_DOUT = bdata(1, b);
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk);
            check($sformatf("stray beat%0d rvalid", b), 64'(rvalid), 64'd0);
            check($sformatf("stray beat%0d rdata", b), rdata, 64'd0);
        end
        DDRAM_DOUT_READY = 1'b0;
        req = 3'b100;
        serve1(2, "post reset");
        req = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
